digit_serial_alu: RTL
=====================

DIGIT_SERIAL_ALU -- requirements
Module: digit_serial_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter DIGIT, default 4, bits processed per cycle; WIDTH SHALL be a multiple of DIGIT; N = WIDTH/DIGIT.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operands/op presented.
REQ-006 in_ready  output  1  block can accept a new operation.
REQ-007 a, b  input  WIDTH  operands, two's complement.
REQ-008 op  input  3  op[2] = binv (invert b, carry-in 1); op[1:0]: 00 AND, 01 OR, 10 ADD, 11 SLT.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  operation result.
REQ-012 cout  output  1  carry out of MSB of the adder.
REQ-013 overflow, zero  output  1 each  signed overflow of adder; result == 0.

Function
REQ-014 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 IDLE -> BUSY on in_valid & in_ready; a, b (after binv), op and carry-in = op[2] SHALL be captured on that edge.
REQ-016 BUSY SHALL process one DIGIT-bit slice per cycle, LSB slice first, carry held in a register between slices; a digit counter 0..N-1 SHALL track the slice.
REQ-017 BUSY -> DONE on the edge completing slice N-1; out_valid SHALL rise exactly N edges after the accepting edge.
REQ-018 DONE -> IDLE on out_valid & out_ready; result and flags SHALL hold stable while out_valid & !out_ready.
REQ-019 AND/OR: result slice = a slice AND/OR b' slice (b' = b or ~b per binv); cout = final adder carry still computed.
REQ-020 ADD (op 010): result = a + b mod 2^WIDTH; SUB (op 110): result = a + ~b + 1.
REQ-021 SLT (op x11): adder computes a + ~b + 1 regardless of op[2]; result = {WIDTH-1 zeros, set}, set = MSB of sum XOR overflow; result register SHALL be written only after slice N-1.
REQ-022 overflow = carry into MSB XOR carry out of MSB; zero = (result == 0); both valid with out_valid.
REQ-023 N = 1 (DIGIT = WIDTH) SHALL give one BUSY cycle; no combinational path from in_valid or out_ready to any output.
REQ-024 in_valid during BUSY/DONE SHALL be ignored (not captured).

Reset
REQ-025 reset SHALL force state IDLE, digit counter 0, carry 0, in_ready 1, out_valid 0, result 0, cout 0, overflow 0, zero 0.
REQ-026 reset asserted during BUSY or DONE SHALL abort the operation; no out_valid for it; next accepted operation SHALL be correct.
REQ-027 reset SHALL take priority over every handshake on the same edge.

Configuration
REQ-028 Macro DIGIT_SERIAL_ALU_FLAGS_EN: when defined, overflow and zero SHALL be computed per REQ-022 and registered.
REQ-029 Without DIGIT_SERIAL_ALU_FLAGS_EN, overflow and zero ports SHALL remain present and be driven constant 0; result, cout and SLT SHALL be unaffected (SLT overflow correction is internal).

Verification (WIDTH=32, DIGIT=4, N=8)
REQ-030 ADD a=0xFFFFFFFF b=0x00000001 -> result 0x00000000, cout 1, zero 1, overflow 0, out_valid 8 edges after accept.
REQ-031 SUB a=0x80000000 b=0x00000001 -> result 0x7FFFFFFF, overflow 1, zero 0.
REQ-032 SLT a=0xFFFFFFFF b=0x00000001 -> result 1; SLT a=0x7FFFFFFF b=0x80000000 -> result 0 (overflow-corrected).
REQ-033 AND a=0xF0F0F0F0 b=0xFF00FF00 -> 0xF000F000; OR same operands -> 0xFFF0FFF0; out_ready held low 5 cycles -> result/flags stable, in_ready 0 throughout.
REQ-034 reset pulsed at 3rd BUSY cycle of ADD -> out_valid never asserted, in_ready 1 next cycle; following ADD 5+7 -> result 12.
REQ-035 Build without DIGIT_SERIAL_ALU_FLAGS_EN, rerun REQ-031 -> result 0x7FFFFFFF, overflow 0, zero 0.

Source files
------------

// File: rtl/digit_serial_alu.sv
// Digit-serial ALU (AND/OR/ADD/SUB/SLT) processing DIGIT bits per cycle, LSB slice first.
// Optional macro DIGIT_SERIAL_ALU_FLAGS_EN enables the registered overflow and zero flags.
module digit_serial_alu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);

   // WIDTH must be a multiple of DIGIT
   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic                    carry;
   logic [1:0]              op_r;
   logic [N-1:0][DIGIT-1:0] a_r;
   logic [N-1:0][DIGIT-1:0] b_r;
   logic [N-1:0][DIGIT-1:0] acc;

   logic                    sub;
   logic [DIGIT-1:0]        a_s;
   logic [DIGIT-1:0]        b_s;
   logic [DIGIT:0]          sum_ext;
   logic [DIGIT-1:0]        sum_s;
   logic [DIGIT-1:0]        slice_s;
   logic                    c_msb;
   logic                    ovf_s;
   logic                    set_s;
   logic [N-1:0][DIGIT-1:0] res_full;
   logic [WIDTH-1:0]        res_next;

   // SLT always subtracts, regardless of binv
   assign sub = op[2] | (op[1:0] == 2'b11);

   // Current slice: adder, logic ops, and the assembled result for the final slice
   always_comb begin
      a_s      = a_r[cnt];
      b_s      = b_r[cnt];
      sum_ext  = {1'b0, a_s} + {1'b0, b_s} + {{DIGIT{1'b0}}, carry};
      sum_s    = sum_ext[DIGIT-1:0];
      c_msb    = a_s[DIGIT-1] ^ b_s[DIGIT-1] ^ sum_s[DIGIT-1];
      ovf_s    = c_msb ^ sum_ext[DIGIT];
      set_s    = sum_s[DIGIT-1] ^ ovf_s;
      case (op_r)
         2'b00:   slice_s = a_s & b_s;
         2'b01:   slice_s = a_s | b_s;
         default: slice_s = sum_s;
      endcase
      res_full      = acc;
      res_full[cnt] = slice_s;
      res_next      = (op_r == 2'b11) ? WIDTH'(set_s) : res_full;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         carry     <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         cout      <= 1'b0;
`ifdef DIGIT_SERIAL_ALU_FLAGS_EN
         overflow  <= 1'b0;
         zero      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_r      <= a;
                  b_r      <= sub ? ~b : b;
                  op_r     <= op[1:0];
                  carry    <= sub;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               acc[cnt] <= slice_s;
               carry    <= sum_ext[DIGIT];
               cnt      <= cnt + CW'(1);
               if (cnt == LAST) begin
                  cnt       <= '0;
                  result    <= res_next;
                  cout      <= sum_ext[DIGIT];
`ifdef DIGIT_SERIAL_ALU_FLAGS_EN
                  overflow  <= ovf_s;
                  zero      <= (res_next == '0);
`endif
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef DIGIT_SERIAL_ALU_FLAGS_EN
   assign overflow = 1'b0;
   assign zero     = 1'b0;
`endif

endmodule
